nios_debug_ocimem_master: RTL and testbench

//  Sysclk-side consumer of the debug-slave JTAG command stream (jdo + take_action_* strobes).

---
 rtl/debug_ocimem_pkg.sv | 8 +
 rtl/nios_debug_wait_timer.sv | 17 +
 rtl/nios_debug_ocimem_master.sv | 76 +++++++
 tb/tb_nios_debug_ocimem_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/debug_ocimem_pkg.sv
// debug_ocimem_pkg: shared FSM states, jdo field indices and byte-enable constant
package debug_ocimem_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  localparam int JDO_LOAD = 34;
  localparam int JDO_RDEN = 35;
  localparam int JDO_DATA_HI = 31;
  localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/nios_debug_wait_timer.sv
// nios_debug_wait_timer: saturating stall counter that flags the stall cycle reaching TIMEOUT
module nios_debug_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  logic [15:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != 16'(TIMEOUT)) r_cnt <= r_cnt + 16'd1;
  end
  assign o_expired = i_inc && r_cnt == 16'(TIMEOUT - 1);
endmodule

// File: rtl/nios_debug_ocimem_master.sv
// nios_debug_ocimem_master: turns JTAG ocimem commands into single-word Avalon-MM accesses
module nios_debug_ocimem_master
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_mon;
  logic r_err;
  logic w_idle, w_done, w_expired, w_load, w_rd_go, w_wr_go, w_collide, w_unused;
  wire w_a = take_action_ocimem_a;
  wire w_b = take_action_ocimem_b;
  wire w_n = take_no_action_ocimem_a;
  assign w_unused = ^{jdo[37:36], jdo[33:32]};
  assign w_idle = r_state == IDLE;
  assign w_done = !w_idle && !avm_waitrequest;
  assign w_load = w_idle && w_a && jdo[JDO_LOAD];
  assign w_rd_go = w_idle && (w_a ? jdo[JDO_LOAD] && jdo[JDO_RDEN] : !w_b && w_n);
  assign w_wr_go = w_idle && !w_a && w_b;
  // Losing strobes in IDLE, or any strobe while busy, are dropped as errors
  assign w_collide = w_idle ? (w_a && (w_b || w_n)) || (w_b && w_n) : (w_a || w_b || w_n);
  nios_debug_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(reset),
    .i_clr(w_idle),
    .i_inc(!w_idle && avm_waitrequest),
    .o_expired(w_expired)
  );
  always_comb begin
    w_next = w_rd_go ? RD : w_wr_go ? WR : (w_done || w_expired) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_mon <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) r_addr <= {jdo[ADDR_W-1:2], 2'b00};
      else if (w_done) r_addr <= r_addr + ADDR_W'(4);
      if (w_wr_go) r_mon <= jdo[JDO_DATA_HI:0];
      else if (w_done && r_state == RD) r_mon <= avm_readdata;
      else if (w_expired) r_mon <= '0;
      if (w_collide || w_expired) r_err <= 1'b1;
      else if (w_load) r_err <= 1'b0;
    end
  end
  assign avm_address = r_addr;
  assign avm_read = r_state == RD;
  assign avm_write = r_state == WR;
  assign avm_writedata = r_mon;
  assign avm_byteenable = BE_ALL;
  assign MonDReg = r_mon;
  assign monitor_ready = w_idle;
  assign monitor_error = r_err;
endmodule

// File: tb/tb_nios_debug_ocimem_master.sv
// tb_nios_debug_ocimem_master: directed scenarios with hand-computed expectations
module tb_nios_debug_ocimem_master;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [37:0] jdo = '0;
  logic sa = 1'b0, sn = 1'b0, sb = 1'b0;
  logic [31:0] avm_address, avm_writedata, avm_readdata = '0, MonDReg;
  logic avm_read, avm_write, avm_waitrequest = 1'b0, monitor_ready, monitor_error;
  logic [3:0] avm_byteenable;
  int n_checks = 0, n_fail = 0;

  nios_debug_ocimem_master #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_no_action_ocimem_a(sn), .take_action_ocimem_b(sb),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input logic rd, input logic ld, input logic [31:0] v);
    return {2'b11, rd, ld, 2'b11, v};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic n, input logic b, input logic [37:0] d);
    sa = a; sn = n; sb = b; jdo = d;
    tick();
    sa = 0; sn = 0; sb = 0;
  endtask

  task automatic test_reset;
    reset = 1; tick(); tick(); reset = 0;
    n_checks++; if ({avm_read, avm_write, monitor_ready, monitor_error} !== 4'b0010) begin n_fail++; $display("FAIL reset_flags: got %b expected 0010", {avm_read, avm_write, monitor_ready, monitor_error}); end
    n_checks++; if ({avm_address, MonDReg, avm_writedata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {avm_address, MonDReg, avm_writedata}); end
    n_checks++; if (avm_byteenable !== 4'hF) begin n_fail++; $display("FAIL byteenable: got %h expected f", avm_byteenable); end
  endtask

  task automatic test_load_read;
    avm_waitrequest = 0; avm_readdata = 32'hCAFEF00D;
    pulse(1, 0, 0, mk(1, 1, 32'h1000));
    n_checks++; if ({avm_read, monitor_ready, avm_address} !== {2'b10, 32'h1000}) begin n_fail++; $display("FAIL lr_req: got rd=%b rdy=%b a=%h expected 1 0 1000", avm_read, monitor_ready, avm_address); end
    tick();
    n_checks++; if ({avm_read, monitor_ready, monitor_error, MonDReg} !== {3'b010, 32'hCAFEF00D}) begin n_fail++; $display("FAIL lr_done: got rd=%b rdy=%b err=%b d=%h expected 0 1 0 cafef00d", avm_read, monitor_ready, monitor_error, MonDReg); end
    avm_readdata = 32'h11111111;
    pulse(0, 1, 0, '0);
    n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h1004}) begin n_fail++; $display("FAIL lr_next_addr: got rd=%b a=%h expected 1 1004", avm_read, avm_address); end
    tick();
    n_checks++; if (MonDReg !== 32'h11111111) begin n_fail++; $display("FAIL lr_next_data: got %h expected 11111111", MonDReg); end
  endtask

  task automatic test_write_stall;
    int writes = 0;
    int stable = 0;
    avm_waitrequest = 1;
    pulse(0, 0, 1, mk(0, 0, 32'h12345678));
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) avm_waitrequest = 0;
      if (avm_write && avm_address == 32'h1008 && avm_writedata == 32'h12345678) stable++;
      if (avm_write && !avm_waitrequest) writes++;
      if (i < 6) tick();
    end
    tick();
    n_checks++; if (stable !== 6) begin n_fail++; $display("FAIL wr_stable: got %0d expected 6", stable); end
    n_checks++; if (writes !== 1) begin n_fail++; $display("FAIL wr_count: got %0d expected 1", writes); end
    n_checks++; if ({avm_write, monitor_ready, monitor_error, MonDReg} !== {3'b010, 32'h12345678}) begin n_fail++; $display("FAIL wr_done: got wr=%b rdy=%b err=%b d=%h expected 0 1 0 12345678", avm_write, monitor_ready, monitor_error, MonDReg); end
    pulse(0, 1, 0, '0);
    n_checks++; if (avm_address !== 32'h100C) begin n_fail++; $display("FAIL wr_addr_inc: got %h expected 100c", avm_address); end
    tick();
  endtask

  task automatic test_timeout;
    int hi = 0;
    avm_waitrequest = 1;
    pulse(1, 0, 0, mk(1, 1, 32'h2000));
    for (int i = 1; i <= 8; i++) begin
      if (avm_read) hi++;
      tick();
    end
    n_checks++; if (hi !== 8) begin n_fail++; $display("FAIL to_read_cycles: got %0d expected 8", hi); end
    n_checks++; if ({avm_read, monitor_ready, monitor_error, MonDReg} !== {3'b011, 32'h0}) begin n_fail++; $display("FAIL to_abandon: got rd=%b rdy=%b err=%b d=%h expected 0 1 1 0", avm_read, monitor_ready, monitor_error, MonDReg); end
    avm_waitrequest = 0; avm_readdata = 32'h22222222;
    pulse(0, 1, 0, '0);
    n_checks++; if (avm_address !== 32'h2000) begin n_fail++; $display("FAIL to_addr_kept: got %h expected 2000", avm_address); end
    tick();
    pulse(1, 0, 0, mk(0, 1, 32'h3000));
    n_checks++; if ({avm_read, monitor_ready, monitor_error} !== 3'b010) begin n_fail++; $display("FAIL to_err_clear: got rd=%b rdy=%b err=%b expected 0 1 0", avm_read, monitor_ready, monitor_error); end
  endtask

  task automatic test_busy_collision;
    int reads = 0;
    avm_waitrequest = 1;
    pulse(1, 0, 0, mk(1, 1, 32'h4000));
    pulse(0, 1, 0, '0);
    n_checks++; if ({avm_read, monitor_error, avm_address} !== {2'b11, 32'h4000}) begin n_fail++; $display("FAIL bc_dropped: got rd=%b err=%b a=%h expected 1 1 4000", avm_read, monitor_error, avm_address); end
    avm_waitrequest = 0; avm_readdata = 32'hA5A55A5A;
    for (int i = 0; i < 3; i++) begin
      if (avm_read && !avm_waitrequest) reads++;
      tick();
    end
    n_checks++; if (reads !== 1) begin n_fail++; $display("FAIL bc_reads: got %0d expected 1", reads); end
    n_checks++; if ({monitor_ready, monitor_error, MonDReg} !== {2'b11, 32'hA5A55A5A}) begin n_fail++; $display("FAIL bc_done: got rdy=%b err=%b d=%h expected 1 1 a5a55a5a", monitor_ready, monitor_error, MonDReg); end
    pulse(1, 0, 1, mk(0, 1, 32'h5000));
    n_checks++; if ({avm_write, monitor_ready, monitor_error} !== 3'b011) begin n_fail++; $display("FAIL idle_priority: got wr=%b rdy=%b err=%b expected 0 1 1", avm_write, monitor_ready, monitor_error); end
  endtask

  task automatic test_wrap;
    avm_waitrequest = 0; avm_readdata = 32'h1;
    pulse(1, 0, 0, mk(1, 1, 32'hFFFF_FFFF));
    n_checks++; if (avm_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got %h expected fffffffc", avm_address); end
    tick();
    pulse(0, 1, 0, '0);
    n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_second: got rd=%b a=%h expected 1 0", avm_read, avm_address); end
    tick();
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b expected 0", monitor_error); end
  endtask

  task automatic test_reset_mid_write;
    avm_waitrequest = 1;
    pulse(1, 0, 0, mk(0, 1, 32'h6000));
    pulse(0, 0, 1, mk(0, 0, 32'hDEADBEEF));
    pulse(0, 1, 0, '0);
    n_checks++; if ({avm_write, monitor_error} !== 2'b11) begin n_fail++; $display("FAIL rm_pre: got wr=%b err=%b expected 1 1", avm_write, monitor_error); end
    reset = 1; tick(); reset = 0;
    n_checks++; if ({avm_write, monitor_ready, monitor_error, MonDReg} !== {3'b010, 32'h0}) begin n_fail++; $display("FAIL rm_post: got wr=%b rdy=%b err=%b d=%h expected 0 1 0 0", avm_write, monitor_ready, monitor_error, MonDReg); end
    avm_waitrequest = 0;
    pulse(0, 1, 0, '0);
    n_checks++; if ({avm_read, avm_address} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rm_addr: got rd=%b a=%h expected 1 0", avm_read, avm_address); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_write_stall();
    test_timeout();
    test_busy_collision();
    test_wrap();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
